dm_port_ctrl: RTL and testbench

Sequencing and arbitration controller in front of the byte-addressed, little-endian data memory. The data memory reads combinationally and writes 4 bytes on the clock edge. Two requesters share it: the pipeline MEM stage (CPU) and a word-wide debug/loader port (DBG). The block adds sub-word loads with sign/zero extension, implements sub-word stores (sb/sh) as a 2-cycle read-modify-write, and stalls the pipeline when the memory is busy.

---
 rtl/dm_port_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_dm_port_ctrl.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_port_ctrl.sv
// -----------------------------------------------------------------------------
// dm_port_ctrl
// Sequencing and arbitration controller in front of a byte-addressed,
// little-endian data memory that reads combinationally and writes a full
// 32-bit word on the clock edge.
//
// Two requesters share the memory:
//   - CPU (pipeline MEM stage): byte/half/word loads with sign or zero
//     extension, word stores in one cycle, and byte/half stores as a
//     two-cycle read-modify-write (read in the grant cycle, write next).
//   - DBG (debug/loader port): word reads and writes, completed with a
//     registered one-cycle dbg_ack pulse.
//
// Ports:
//   clk, rst                  clock and asynchronous active-high reset
//   cpu_req/we/size/sext      CPU access request and its attributes
//   cpu_addr, cpu_wdata       CPU byte address and store data
//   cpu_rdata                 extended load data (combinational)
//   cpu_stall                 pipeline must hold the MEM-stage request
//   dbg_req/we/addr/wdata     DBG request, held until dbg_ack
//   dbg_ack, dbg_rdata        registered completion pulse and read word
//   dm_rd, dm_wr              data-memory read / write enables
//   dm_addr, dm_wdata         data-memory byte address and write data
//   dm_rdata                  data-memory read data (combinational)
// -----------------------------------------------------------------------------
module dm_port_ctrl #(
    parameter int AW           = 7,
    parameter int STARVE_LIMIT = 8,
    parameter int CW           = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [1:0]    cpu_size,
    input  logic          cpu_sext,
    input  logic [AW-1:0] cpu_addr,
    input  logic [31:0]   cpu_wdata,
    output logic [31:0]   cpu_rdata,
    output logic          cpu_stall,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [31:0]   dbg_wdata,
    output logic          dbg_ack,
    output logic [31:0]   dbg_rdata,
    output logic          dm_rd,
    output logic          dm_wr,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_wdata,
    input  logic [31:0]   dm_rdata
);

    typedef enum logic {
        IDLE,
        RMW_WR
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   old_word;

    logic starved;
    logic dbg_grant;
    logic cpu_grant;
    logic cpu_sub;

    // Arbitration is only meaningful in IDLE; RMW_WR belongs to the CPU.
    // DBG takes the memory when the CPU is quiet, or when it has waited
    // long enough that it must be let through regardless of the CPU.
    always_comb begin
        starved   = (wait_cnt == CW'(STARVE_LIMIT));
        dbg_grant = (state == IDLE) && dbg_req && (starved || !cpu_req);
        cpu_grant = (state == IDLE) && cpu_req && !dbg_grant;
        cpu_sub   = cpu_we && !cpu_size[1];
    end

    // State register; a reset during RMW_WR simply abandons the merge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: only a granted byte/half store leaves IDLE, and
    // the write half of the read-modify-write always returns to IDLE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (cpu_grant && cpu_sub) begin
                    next_state = RMW_WR;
                end
            end
            RMW_WR: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Memory-side and stall outputs. Everything is held at zero while
    // reset is asserted so the memory sees no stray write mid-RMW.
    always_comb begin
        dm_rd     = 1'b0;
        dm_wr     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        cpu_stall = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (dbg_grant) begin
                        dm_rd     = !dbg_we;
                        dm_wr     = dbg_we;
                        dm_addr   = dbg_addr;
                        dm_wdata  = dbg_wdata;
                        cpu_stall = cpu_req;
                    end else if (cpu_grant) begin
                        dm_addr = cpu_addr;
                        if (!cpu_we) begin
                            dm_rd = 1'b1;
                        end else if (cpu_sub) begin
                            dm_rd     = 1'b1;
                            cpu_stall = 1'b1;
                        end else begin
                            dm_wr    = 1'b1;
                            dm_wdata = cpu_wdata;
                        end
                    end
                end
                RMW_WR: begin
                    dm_wr   = 1'b1;
                    dm_addr = cpu_addr;
                    if (cpu_size[0]) begin
                        dm_wdata = {old_word[31:16], cpu_wdata[15:0]};
                    end else begin
                        dm_wdata = {old_word[31:8], cpu_wdata[7:0]};
                    end
                end
                default: begin
                    dm_rd = 1'b0;
                end
            endcase
        end
    end

    // Load extension straight off the memory read bus; size 11 is a word.
    always_comb begin
        case (cpu_size)
            2'b00:   cpu_rdata = cpu_sext ? {{24{dm_rdata[7]}}, dm_rdata[7:0]}
                                          : {24'd0, dm_rdata[7:0]};
            2'b01:   cpu_rdata = cpu_sext ? {{16{dm_rdata[15]}}, dm_rdata[15:0]}
                                          : {16'd0, dm_rdata[15:0]};
            default: cpu_rdata = dm_rdata;
        endcase
    end

    // DBG wait counter: counts every cycle DBG is asking but not served,
    // saturating at the starvation limit, and clears on grant or release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (dbg_grant || !dbg_req) begin
            wait_cnt <= '0;
        end else if (!starved) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // Capture the old word during the read half of a byte/half store.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            old_word <= '0;
        end else if (cpu_grant && cpu_sub) begin
            old_word <= dm_rdata;
        end
    end

    // DBG completion: ack pulses the cycle after a grant; read data is
    // registered alongside it and left untouched by writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbg_ack   <= 1'b0;
            dbg_rdata <= '0;
        end else begin
            dbg_ack <= dbg_grant;
            if (dbg_grant && !dbg_we) begin
                dbg_rdata <= dm_rdata;
            end
        end
    end

endmodule

// File: tb/tb_dm_port_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dm_port_ctrl
// Directed bench for dm_port_ctrl with a behavioural 128-byte little-endian
// memory attached to the dm_* port. Inputs change 1 time unit after the
// rising edge; outputs are checked on the falling edge.
// -----------------------------------------------------------------------------
module tb_dm_port_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [1:0]  cpu_size;
    logic        cpu_sext;
    logic [6:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [6:0]  dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_ack;
    logic [31:0] dbg_rdata;
    logic        dm_rd;
    logic        dm_wr;
    logic [6:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic [31:0] dm_rdata;

    int total = 0;
    int bad   = 0;

    dm_port_ctrl #(.AW(7), .STARVE_LIMIT(8), .CW(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_size  (cpu_size),
        .cpu_sext  (cpu_sext),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_ack   (dbg_ack),
        .dbg_rdata (dbg_rdata),
        .dm_rd     (dm_rd),
        .dm_wr     (dm_wr),
        .dm_addr   (dm_addr),
        .dm_wdata  (dm_wdata),
        .dm_rdata  (dm_rdata)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: combinational read, word write on the edge.
    logic [7:0] mem [0:127];
    logic [6:0] a1, a2, a3;
    assign a1 = dm_addr + 7'd1;
    assign a2 = dm_addr + 7'd2;
    assign a3 = dm_addr + 7'd3;
    assign dm_rdata = {mem[a3], mem[a2], mem[a1], mem[dm_addr]};

    always @(posedge clk) begin
        if (dm_wr) begin
            mem[dm_addr] <= dm_wdata[7:0];
            mem[a1]      <= dm_wdata[15:8];
            mem[a2]      <= dm_wdata[23:16];
            mem[a3]      <= dm_wdata[31:24];
        end
    end

    // Watchdog so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_size  = 2'b10;
        cpu_sext  = 1'b0;
        cpu_addr  = 7'h00;
        cpu_wdata = 32'h0;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = 7'h00;
        dbg_wdata = 32'h0;
    endtask

    // Preload a word through the DBG port with the CPU idle.
    task automatic dbg_write(input logic [6:0] addr, input logic [31:0] data);
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = addr;
        dbg_wdata = data;
        tick();
        dbg_req = 1'b0;
        dbg_we  = 1'b0;
        @(negedge clk);
        total++;
        if (dbg_ack !== 1'b1) begin
            bad++;
            $display("[TB] FAIL preload_ack @%h: got %b want 1", addr, dbg_ack);
        end
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst       = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 7'h33;
        cpu_wdata = 32'h12345678;
        dbg_req   = 1'b1;
        dbg_addr  = 7'h44;
        @(negedge clk);
        total++;
        if ({dm_rd, dm_wr, cpu_stall, dbg_ack} !== 4'b0000) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got rd/wr/stall/ack=%b want 0000",
                     {dm_rd, dm_wr, cpu_stall, dbg_ack});
        end
        total++;
        if (dm_addr !== 7'h00 || dm_wdata !== 32'h0 || dbg_rdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0",
                     dm_addr, dm_wdata, dbg_rdata);
        end
        tick();
        idle_inputs();
        rst = 1'b0;
        @(negedge clk);
        total++;
        if ({dm_rd, dm_wr, cpu_stall, dbg_ack} !== 4'b0000 || dm_addr !== 7'h00 ||
            dm_wdata !== 32'h0) begin
            bad++;
            $display("[TB] FAIL idle_outputs: got rd/wr/stall/ack=%b addr=%h wdata=%h want 0",
                     {dm_rd, dm_wr, cpu_stall, dbg_ack}, dm_addr, dm_wdata);
        end
        tick();
    endtask

    task automatic test_dbg_port();
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 7'h04;
        dbg_wdata = 32'hDEADBEEF;
        @(negedge clk);
        total++;
        if (dm_wr !== 1'b1 || dm_rd !== 1'b0 || dm_addr !== 7'h04 || dm_wdata !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL dbg_write_cycle: got wr=%b rd=%b addr=%h wdata=%h want 1 0 04 deadbeef",
                     dm_wr, dm_rd, dm_addr, dm_wdata);
        end
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        total++;
        if (dbg_ack !== 1'b1) begin
            bad++;
            $display("[TB] FAIL dbg_write_ack: got %b want 1", dbg_ack);
        end
        tick();
        dbg_req = 1'b1;
        dbg_we  = 1'b0;
        @(negedge clk);
        total++;
        if (dbg_ack !== 1'b0 || dm_rd !== 1'b1 || dm_wr !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dbg_read_cycle: got ack=%b rd=%b wr=%b want 0 1 0",
                     dbg_ack, dm_rd, dm_wr);
        end
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        total++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL dbg_read_data: got ack=%b rdata=%h want 1 deadbeef",
                     dbg_ack, dbg_rdata);
        end
        tick();
        @(negedge clk);
        total++;
        if (dbg_ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL dbg_ack_pulse: got %b want 0", dbg_ack);
        end
        tick();
    endtask

    task automatic test_loads();
        logic [1:0]  sizes [6] = '{2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b01};
        logic        sexts [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [6:0]  addrs [6] = '{7'h10, 7'h10, 7'h10, 7'h10, 7'h20, 7'h20};
        logic [31:0] exps  [6] = '{32'hFFFFFF80, 32'h00000080, 32'h00007F80,
                                   32'h02017F80, 32'hFFFFCCDD, 32'h0000CCDD};
        dbg_write(7'h10, 32'h02017F80);
        dbg_write(7'h20, 32'hAABBCCDD);
        for (int i = 0; i < 6; i++) begin
            cpu_req  = 1'b1;
            cpu_we   = 1'b0;
            cpu_size = sizes[i];
            cpu_sext = sexts[i];
            cpu_addr = addrs[i];
            @(negedge clk);
            total++;
            if (cpu_rdata !== exps[i] || cpu_stall !== 1'b0 || dm_rd !== 1'b1 ||
                dm_addr !== addrs[i]) begin
                bad++;
                $display("[TB] FAIL load_%0d: got rdata=%h stall=%b rd=%b addr=%h want %h 0 1 %h",
                         i, cpu_rdata, cpu_stall, dm_rd, dm_addr, exps[i], addrs[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_subword_store();
        logic [1:0]  sizes [2] = '{2'b00, 2'b01};
        logic [31:0] wd    [2] = '{32'h12345611, 32'h99992233};
        logic [31:0] exps  [2] = '{32'hAABBCC11, 32'hAABB2233};
        for (int i = 0; i < 2; i++) begin
            cpu_req   = 1'b1;
            cpu_we    = 1'b1;
            cpu_size  = sizes[i];
            cpu_addr  = 7'h20;
            cpu_wdata = wd[i];
            @(negedge clk);
            total++;
            if (dm_rd !== 1'b1 || dm_wr !== 1'b0 || cpu_stall !== 1'b1) begin
                bad++;
                $display("[TB] FAIL rmw_read_%0d: got rd=%b wr=%b stall=%b want 1 0 1",
                         i, dm_rd, dm_wr, cpu_stall);
            end
            tick();
            @(negedge clk);
            total++;
            if (dm_wr !== 1'b1 || dm_rd !== 1'b0 || cpu_stall !== 1'b0 ||
                dm_addr !== 7'h20 || dm_wdata !== exps[i]) begin
                bad++;
                $display("[TB] FAIL rmw_write_%0d: got wr=%b rd=%b stall=%b addr=%h wdata=%h want 1 0 0 20 %h",
                         i, dm_wr, dm_rd, cpu_stall, dm_addr, dm_wdata, exps[i]);
            end
            tick();
            cpu_we   = 1'b0;
            cpu_size = 2'b10;
            @(negedge clk);
            total++;
            if (cpu_rdata !== exps[i] || cpu_stall !== 1'b0) begin
                bad++;
                $display("[TB] FAIL rmw_readback_%0d: got %h stall=%b want %h 0",
                         i, cpu_rdata, cpu_stall, exps[i]);
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_starvation();
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_size = 2'b10;
        cpu_addr = 7'h04;
        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = 7'h20;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            total++;
            if (cpu_stall !== 1'b0 || dm_addr !== 7'h04 || cpu_rdata !== 32'hDEADBEEF) begin
                bad++;
                $display("[TB] FAIL starve_cpu_%0d: got stall=%b addr=%h rdata=%h want 0 04 deadbeef",
                         i, cpu_stall, dm_addr, cpu_rdata);
            end
            tick();
        end
        @(negedge clk);
        total++;
        if (cpu_stall !== 1'b1 || dm_addr !== 7'h20 || dm_rd !== 1'b1 || dbg_ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL starve_dbg_grant: got stall=%b addr=%h rd=%b ack=%b want 1 20 1 0",
                     cpu_stall, dm_addr, dm_rd, dbg_ack);
        end
        tick();
        // DBG keeps requesting in the ack cycle: a fresh request with a
        // cleared counter must lose to the CPU.
        @(negedge clk);
        total++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hAABB2233) begin
            bad++;
            $display("[TB] FAIL starve_ack: got ack=%b rdata=%h want 1 aabb2233",
                     dbg_ack, dbg_rdata);
        end
        total++;
        if (cpu_stall !== 1'b0 || dm_addr !== 7'h04) begin
            bad++;
            $display("[TB] FAIL starve_cnt_cleared: got stall=%b addr=%h want 0 04",
                     cpu_stall, dm_addr);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_mid_rmw();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_size  = 2'b00;
        cpu_addr  = 7'h20;
        cpu_wdata = 32'h00000055;
        @(negedge clk);
        total++;
        if (dm_rd !== 1'b1 || cpu_stall !== 1'b1) begin
            bad++;
            $display("[TB] FAIL rst_rmw_read: got rd=%b stall=%b want 1 1", dm_rd, cpu_stall);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (dm_wr !== 1'b0 || cpu_stall !== 1'b0 || dbg_ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_rmw_hold: got wr=%b stall=%b ack=%b want 0 0 0",
                     dm_wr, cpu_stall, dbg_ack);
        end
        tick();
        rst = 1'b0;
        cpu_we   = 1'b0;
        cpu_size = 2'b10;
        @(negedge clk);
        total++;
        if (cpu_rdata !== 32'hAABB2233 || dm_wr !== 1'b0 || dm_rd !== 1'b1 || cpu_stall !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rst_rmw_after: got rdata=%h wr=%b rd=%b stall=%b want aabb2233 0 1 0",
                     cpu_rdata, dm_wr, dm_rd, cpu_stall);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_dbg_during_rmw();
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_size  = 2'b00;
        cpu_addr  = 7'h10;
        cpu_wdata = 32'h00000066;
        dbg_req   = 1'b1;
        dbg_we    = 1'b0;
        dbg_addr  = 7'h04;
        @(negedge clk);
        total++;
        if (cpu_stall !== 1'b1 || dm_rd !== 1'b1 || dm_addr !== 7'h10) begin
            bad++;
            $display("[TB] FAIL rmwdbg_read: got stall=%b rd=%b addr=%h want 1 1 10",
                     cpu_stall, dm_rd, dm_addr);
        end
        tick();
        @(negedge clk);
        total++;
        if (dm_wr !== 1'b1 || dm_addr !== 7'h10 || dm_wdata !== 32'h02017F66 || dbg_ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmwdbg_write: got wr=%b addr=%h wdata=%h ack=%b want 1 10 02017f66 0",
                     dm_wr, dm_addr, dm_wdata, dbg_ack);
        end
        tick();
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        @(negedge clk);
        total++;
        if (dm_rd !== 1'b1 || dm_wr !== 1'b0 || dm_addr !== 7'h04 || dbg_ack !== 1'b0) begin
            bad++;
            $display("[TB] FAIL rmwdbg_grant: got rd=%b wr=%b addr=%h ack=%b want 1 0 04 0",
                     dm_rd, dm_wr, dm_addr, dbg_ack);
        end
        tick();
        dbg_req = 1'b0;
        @(negedge clk);
        total++;
        if (dbg_ack !== 1'b1 || dbg_rdata !== 32'hDEADBEEF) begin
            bad++;
            $display("[TB] FAIL rmwdbg_ack: got ack=%b rdata=%h want 1 deadbeef",
                     dbg_ack, dbg_rdata);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        $display("[TB] starting dm_port_ctrl bench");
        test_reset();
        test_dbg_port();
        test_loads();
        test_subword_store();
        test_starvation();
        test_reset_mid_rmw();
        test_dbg_during_rmw();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
